measure_sched: RTL and testbench

- Round-robin scheduler that time-shares one `measure` frequency-counter instance among N_CH external signal inputs.
- Per channel it: selects and muxes the channel, waits for the synchronizer to settle, arms the gate, tracks gate_sync, and collects the 64-bit {ref_cnt, sig_cnt} result.
- Results are presented on a valid/ready port, tagged with channel id and a timeout flag.
- Sits between the AXI register front-end (start/mask/result FIFO) and the measure datapath.

---
 rtl/measure_sched.sv | 177 +++++++++++++++++
 tb/tb_measure_sched.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/measure_sched.sv
// Round-robin scheduler sharing one measure frequency counter among N_CH signal inputs.
// Each channel is muxed in, allowed to settle, gated, and its result presented on a valid/ready port.
module measure_sched #(
  parameter int N_CH          = 4,
  parameter int SETTLE_CYCLES = 4,
  parameter int ARM_TIMEOUT   = 1_000_000,
  parameter int MEAS_TIMEOUT  = 200_000_000,
  localparam int SEL_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              continuous_i,
  input  logic [N_CH-1:0]   ch_en_i,
  input  logic [N_CH-1:0]   sig_clk_i,
  output logic              sig_clk_o,
  output logic              gate_en_o,
  output logic              meas_rst_n_o,
  input  logic              gate_sync_i,
  input  logic              meas_wr_en_i,
  input  logic [63:0]       meas_wr_data_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [SEL_W-1:0]  res_ch_o,
  output logic [63:0]       res_data_o,
  output logic              res_timeout_o,
  output logic              busy_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_PICK, S_SETTLE, S_ARM, S_GATE, S_ABORT, S_REPORT
  } state_e;

  localparam logic [31:0] SETTLE_LIM = 32'(SETTLE_CYCLES - 1);
  localparam logic [31:0] ARM_LIM    = 32'(ARM_TIMEOUT - 1);
  localparam logic [31:0] MEAS_LIM   = 32'(MEAS_TIMEOUT - 1);

  state_e            state_q;
  logic [N_CH-1:0]   mask_q;
  logic [SEL_W-1:0]  sel_q;
  logic [SEL_W-1:0]  last_q;
  logic [31:0]       cnt_q;
  logic              gate_en_q;
  logic              meas_rst_n_q;
  logic              res_valid_q;
  logic [SEL_W-1:0]  res_ch_q;
  logic [63:0]       res_data_q;
  logic              res_timeout_q;

  logic [SEL_W-1:0]  pick_d;
  logic [N_CH-1:0]   mask_clr_d;
  logic [31:0]       cnt_inc_d;

  // Round-robin search starting just after the last served channel; walking the
  // offsets downward lets the nearest set bit overwrite any farther candidate.
  always_comb begin
    // NOTE: assign a default before any conditional write so no latch is inferred.
    pick_d = last_q;
    for (int i = N_CH; i >= 1; i--) begin
      if (mask_q[SEL_W'((int'(last_q) + i) % N_CH)]) begin
        pick_d = SEL_W'((int'(last_q) + i) % N_CH);
      end
    end
  end

  assign mask_clr_d = mask_q & ~(N_CH'(1) << sel_q);
  assign cnt_inc_d  = (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= S_IDLE;
      mask_q        <= '0;
      sel_q         <= '0;
      last_q        <= SEL_W'(N_CH - 1);
      cnt_q         <= '0;
      gate_en_q     <= 1'b0;
      meas_rst_n_q  <= 1'b1;
      res_valid_q   <= 1'b0;
      res_ch_q      <= '0;
      res_data_q    <= '0;
      res_timeout_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register update in this block
      // based on the pre-edge values, independent of statement order.
      case (state_q)
        S_IDLE: begin
          if (start_i && (ch_en_i != '0)) begin
            mask_q  <= ch_en_i;
            state_q <= S_PICK;
          end
        end
        S_PICK: begin
          sel_q   <= pick_d;
          cnt_q   <= '0;
          state_q <= S_SETTLE;
        end
        S_SETTLE: begin
          if (cnt_q >= SETTLE_LIM) begin
            cnt_q     <= '0;
            gate_en_q <= 1'b1;
            state_q   <= S_ARM;
          end else begin
            cnt_q <= cnt_inc_d;
          end
        end
        S_ARM: begin
          if (gate_sync_i) begin
            gate_en_q <= 1'b0;
            cnt_q     <= '0;
            state_q   <= S_GATE;
          end else if (cnt_q >= ARM_LIM) begin
            gate_en_q    <= 1'b0;
            meas_rst_n_q <= 1'b0;
            cnt_q        <= '0;
            state_q      <= S_ABORT;
          end else begin
            cnt_q <= cnt_inc_d;
          end
        end
        S_GATE: begin
          if (meas_wr_en_i) begin
            res_data_q    <= meas_wr_data_i;
            res_timeout_q <= 1'b0;
            res_ch_q      <= sel_q;
            res_valid_q   <= 1'b1;
            state_q       <= S_REPORT;
          end else if (cnt_q >= MEAS_LIM) begin
            meas_rst_n_q <= 1'b0;
            cnt_q        <= '0;
            state_q      <= S_ABORT;
          end else begin
            cnt_q <= cnt_inc_d;
          end
        end
        S_ABORT: begin
          // Soft reset held for cycles 0-1, cycle 2 lets measure come out of reset quietly.
          cnt_q <= cnt_inc_d;
          if (cnt_q == 32'd1) meas_rst_n_q <= 1'b1;
          if (cnt_q == 32'd2) begin
            res_data_q    <= '0;
            res_timeout_q <= 1'b1;
            res_ch_q      <= sel_q;
            res_valid_q   <= 1'b1;
            state_q       <= S_REPORT;
          end
        end
        S_REPORT: begin
          if (res_ready_i) begin
            res_valid_q <= 1'b0;
            last_q      <= sel_q;
            if (mask_clr_d != '0) begin
              mask_q  <= mask_clr_d;
              state_q <= S_PICK;
            end else if (continuous_i && (ch_en_i != '0)) begin
              mask_q  <= ch_en_i;
              state_q <= S_PICK;
            end else begin
              mask_q  <= '0;
              state_q <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign sig_clk_o     = sig_clk_i[sel_q];
  assign gate_en_o     = gate_en_q;
  assign meas_rst_n_o  = meas_rst_n_q;
  assign res_valid_o   = res_valid_q;
  assign res_ch_o      = res_ch_q;
  assign res_data_o    = res_data_q;
  assign res_timeout_o = res_timeout_q;
  assign busy_o        = (state_q != S_IDLE);

endmodule

// File: tb/tb_measure_sched.sv
// Bench for measure_sched: a small behavioural measure model feeds the DUT, and
// expected results are queued as each sweep is launched and compared as they appear.
module tb_measure_sched;

  localparam int N_CH    = 4;
  localparam int SETTLE  = 4;
  localparam int ARM_TO  = 100;
  localparam int MEAS_TO = 5000;
  localparam int GATE_T  = 200;
  localparam int WAIT_LIM = 8000;

  logic              clk_i;
  logic              rst_n_i;
  logic              start_i;
  logic              continuous_i;
  logic [N_CH-1:0]   ch_en_i;
  logic [N_CH-1:0]   sig_clk_i;
  logic              sig_clk_o;
  logic              gate_en_o;
  logic              meas_rst_n_o;
  logic              gate_sync_i;
  logic              meas_wr_en_i;
  logic [63:0]       meas_wr_data_i;
  logic              res_valid_o;
  logic              res_ready_i;
  logic [1:0]        res_ch_o;
  logic [63:0]       res_data_o;
  logic              res_timeout_o;
  logic              busy_o;

  measure_sched #(
    .N_CH(N_CH), .SETTLE_CYCLES(SETTLE), .ARM_TIMEOUT(ARM_TO), .MEAS_TIMEOUT(MEAS_TO)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .continuous_i(continuous_i),
    .ch_en_i(ch_en_i), .sig_clk_i(sig_clk_i), .sig_clk_o(sig_clk_o), .gate_en_o(gate_en_o),
    .meas_rst_n_o(meas_rst_n_o), .gate_sync_i(gate_sync_i), .meas_wr_en_i(meas_wr_en_i),
    .meas_wr_data_i(meas_wr_data_i), .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_ch_o(res_ch_o), .res_data_o(res_data_o), .res_timeout_o(res_timeout_o), .busy_o(busy_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int errors;
  int checks;

  typedef struct packed { logic [1:0] ch; logic tmo; } exp_t;
  exp_t        exp_q[$];
  logic [63:0] data_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Signal sources: period 10 clk, each channel phase-shifted; stuck forces a channel low.
  int              div;
  logic [N_CH-1:0] stuck;
  always @(negedge clk_i) begin
    div = (div + 1) % 10;
    for (int c = 0; c < N_CH; c++)
      sig_clk_i[c] = stuck[c] ? 1'b0 : (((div + 2 * c) % 10) < 5);
  end

  // Behavioural measure: starts on a synced signal rise while gated, runs GATE_T
  // reference cycles, then reports {ref, sig} on the next signal rise.
  logic [1:0]  m_sync;
  logic        m_prev;
  logic        m_active;
  logic [31:0] m_ref;
  logic [31:0] m_sig;
  wire         m_rise = m_sync[1] & ~m_prev;

  always @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      m_sync <= '0; m_prev <= 1'b0; m_active <= 1'b0; m_ref <= '0; m_sig <= '0;
      gate_sync_i <= 1'b0; meas_wr_en_i <= 1'b0; meas_wr_data_i <= '0;
    end else begin
      m_sync       <= {m_sync[0], sig_clk_o};
      m_prev       <= m_sync[1];
      meas_wr_en_i <= 1'b0;
      if (!meas_rst_n_o) begin
        m_active <= 1'b0; gate_sync_i <= 1'b0; m_ref <= '0; m_sig <= '0;
      end else if (!m_active) begin
        if (gate_en_o && m_rise) begin
          m_active <= 1'b1; gate_sync_i <= 1'b1; m_ref <= '0; m_sig <= '0;
        end
      end else begin
        m_ref <= m_ref + 32'd1;
        if (m_rise) m_sig <= m_sig + 32'd1;
        if (m_ref >= 32'(GATE_T) && m_rise) begin
          meas_wr_en_i   <= 1'b1;
          meas_wr_data_i <= {m_ref + 32'd1, m_sig + 32'd1};
          data_q.push_back({m_ref + 32'd1, m_sig + 32'd1});
          m_active       <= 1'b0;
          gate_sync_i    <= 1'b0;
        end
      end
    end
  end

  // Run-length monitors for the gate enable and the soft-reset pulse.
  int gate_run, gate_last, rst_run, rst_last;
  always @(posedge clk_i) begin
    if (gate_en_o) gate_run++;
    else begin
      if (gate_run != 0) gate_last = gate_run;
      gate_run = 0;
    end
    if (!meas_rst_n_o) rst_run++;
    else begin
      if (rst_run != 0) rst_last = rst_run;
      rst_run = 0;
    end
  end

  task automatic pulse_start();
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic wait_sync();
    int t = 0;
    while (gate_sync_i !== 1'b1 && t < WAIT_LIM) begin
      @(negedge clk_i);
      t++;
    end
    check("gate_sync_seen", gate_sync_i, 1);
  endtask

  // Waits for a result, holds ready low for 'stall' cycles, then accepts it.
  task automatic get_result(input int stall);
    int          t;
    exp_t        e;
    logic [63:0] expd;
    t = 0;
    while (res_valid_o !== 1'b1 && t < WAIT_LIM) begin
      @(negedge clk_i);
      t++;
    end
    check("result_arrives", res_valid_o, 1);
    if (res_valid_o !== 1'b1) return;
    check("result_expected", exp_q.size() != 0, 1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    if (e.tmo) expd = '0;
    else if (data_q.size() != 0) expd = data_q.pop_front();
    else expd = '1;
    check("res_ch", res_ch_o, e.ch);
    check("res_timeout", res_timeout_o, e.tmo);
    check("res_data", res_data_o, expd);
    if (!e.tmo) begin
      check("sig_cnt_range", (res_data_o[31:0] >= 32'd19) && (res_data_o[31:0] <= 32'd22), 1);
      check("ref_cnt_range", (res_data_o[63:32] >= 32'(GATE_T)) && (res_data_o[63:32] <= 32'(GATE_T + 12)), 1);
    end
    for (int k = 0; k < stall; k++) begin
      @(negedge clk_i);
      check("stall_valid", res_valid_o, 1);
      check("stall_ch", res_ch_o, e.ch);
      check("stall_data", res_data_o, expd);
      check("stall_gate_off", gate_en_o, 0);
    end
    res_ready_i = 1'b1;
    @(negedge clk_i);
    res_ready_i = 1'b0;
    check("valid_drops", res_valid_o, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gate_en"}, gate_en_o, 0);
    check({tag, "_meas_rst_n"}, meas_rst_n_o, 1);
    check({tag, "_res_valid"}, res_valid_o, 0);
    check({tag, "_res_ch"}, res_ch_o, 0);
    check({tag, "_res_data"}, res_data_o, 0);
    check({tag, "_res_timeout"}, res_timeout_o, 0);
    check({tag, "_busy"}, busy_o, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    errors = 0; checks = 0;
    stuck = '0; start_i = 1'b0; continuous_i = 1'b0; ch_en_i = '0; res_ready_i = 1'b0;
    rst_n_i = 1'b1;
    #1 rst_n_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check_reset_outputs("reset");
    check("reset_mux_ch0", sig_clk_o, sig_clk_i[0]);
    rst_n_i = 1'b1;
    @(negedge clk_i);

    // Sweep over 1011 with a 50-cycle stall on the first result and a start while busy.
    ch_en_i = 4'b1011;
    exp_q.push_back('{ch: 2'd0, tmo: 1'b0});
    exp_q.push_back('{ch: 2'd1, tmo: 1'b0});
    exp_q.push_back('{ch: 2'd3, tmo: 1'b0});
    pulse_start();
    check("busy_after_start", busy_o, 1);
    get_result(50);
    ch_en_i = 4'b0100;
    pulse_start();
    get_result(0);
    get_result(0);
    repeat (3) @(negedge clk_i);
    check("sweep1_done_idle", busy_o, 0);

    // Channel 2 never toggles: arm timeout then soft reset.
    stuck[2] = 1'b1;
    ch_en_i  = 4'b0100;
    exp_q.push_back('{ch: 2'd2, tmo: 1'b1});
    pulse_start();
    get_result(0);
    check("arm_gate_len", gate_last, ARM_TO);
    check("arm_rst_len", rst_last, 2);
    stuck[2] = 1'b0;
    repeat (3) @(negedge clk_i);
    check("arm_to_idle", busy_o, 0);

    // Channel 1 dies mid-gate; channel 2 must still measure afterwards.
    ch_en_i = 4'b0110;
    exp_q.push_back('{ch: 2'd1, tmo: 1'b1});
    exp_q.push_back('{ch: 2'd2, tmo: 1'b0});
    pulse_start();
    wait_sync();
    repeat (50) @(negedge clk_i);
    stuck[1] = 1'b1;
    get_result(0);
    check("meas_rst_len", rst_last, 2);
    stuck[1] = 1'b0;
    get_result(0);
    repeat (3) @(negedge clk_i);
    check("meas_to_idle", busy_o, 0);

    // Continuous mode: ch0 twice, then the relatched mask selects ch1 only.
    continuous_i = 1'b1;
    ch_en_i      = 4'b0001;
    exp_q.push_back('{ch: 2'd0, tmo: 1'b0});
    exp_q.push_back('{ch: 2'd0, tmo: 1'b0});
    exp_q.push_back('{ch: 2'd1, tmo: 1'b0});
    pulse_start();
    get_result(0);
    ch_en_i = 4'b0010;
    get_result(0);
    continuous_i = 1'b0;
    get_result(0);
    repeat (3) @(negedge clk_i);
    check("cont_stops_idle", busy_o, 0);

    // Start with an empty mask does nothing.
    ch_en_i = 4'b0000;
    pulse_start();
    repeat (3) @(negedge clk_i);
    check("empty_start_busy", busy_o, 0);
    check("empty_start_valid", res_valid_o, 0);

    // Reset during GATE, then a fresh sweep must begin at ch0.
    ch_en_i = 4'b0001;
    pulse_start();
    wait_sync();
    repeat (20) @(negedge clk_i);
    check("busy_before_rst", busy_o, 1);
    rst_n_i = 1'b0;
    #1;
    check_reset_outputs("midrst");
    data_q.delete();
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
    @(negedge clk_i);
    ch_en_i = 4'b0101;
    exp_q.push_back('{ch: 2'd0, tmo: 1'b0});
    exp_q.push_back('{ch: 2'd2, tmo: 1'b0});
    pulse_start();
    get_result(0);
    get_result(0);
    repeat (3) @(negedge clk_i);
    check("post_rst_idle", busy_o, 0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
